// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D-cache main-memory arbiter
// Contents: FSM state enum, requester ids, default address/line widths.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_LINE_W = 128;
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-cache, D-cache and memory-side signals of the arbiter
// Modports: slave  - the arbiter (takes cache requests and memory response, drives the rest)
//           master - the environment (caches and memory)
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int LINE_W = mem_arb_pkg::DEF_LINE_W
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    modport slave (
        input  i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
               mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
               mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output i_mem_read, i_mem_addr, d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
               mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant between I-cache and D-cache requests
// Ports: i_req_i, d_req_i - pending requests; last_grant_i - requester served last;
//        grant_o - one-hot grant indexed by REQ_I/REQ_D.
// Macro MEM_ARB_ROUND_ROBIN_EN: conflicts go to the requester not served last;
// otherwise the D-cache always wins conflicts.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);
    logic d_first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign d_first = (last_grant_i == REQ_I);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign d_first = 1'b1;
`endif
    assign grant_o[REQ_D] = d_req_i & (d_first | ~i_req_i);
    assign grant_o[REQ_I] = i_req_i & ~grant_o[REQ_D];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared slow-memory port to the I-cache or D-cache, one line at a time
// Ports: clk, rst_n (async, active-low); bus (mem_arbiter_if.slave) carrying the I-cache
//        read port, D-cache read/write-back port and the registered memory port.
// Macro MEM_ARB_ROUND_ROBIN_EN: round-robin conflict resolution with a last-grant register;
// undefined builds use fixed D-cache priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    state_e            state_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic              last_grant;
    logic [1:0]        grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_q;
    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_I;
`endif
    mem_arb_pick u_pick (
        .i_req_i      (bus.i_mem_read),
        .d_req_i      (bus.d_mem_read | bus.d_mem_write),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );
    // A simultaneous D read+write is serviced as a write because mem_write wins in the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant[REQ_I]) begin
                        mem_addr_q <= bus.i_mem_addr;
                        mem_read_q <= 1'b1;
                        state_q    <= BUSY_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= REQ_I;
`endif
                    end else if (grant[REQ_D]) begin
                        mem_addr_q  <= bus.d_mem_addr;
                        mem_wdata_q <= bus.d_mem_wdata;
                        mem_write_q <= bus.d_mem_write;
                        mem_read_q  <= ~bus.d_mem_write;
                        state_q     <= BUSY_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= REQ_D;
`endif
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        mem_read_q <= 1'b0;
                        i_rdata_q  <= bus.mem_rdata;
                        i_ready_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (mem_read_q) d_rdata_q <= bus.mem_rdata;
                        d_ready_q   <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    // The winner still holds its request here; it is deliberately not sampled.
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_mem_rdata = i_rdata_q;
    assign bus.d_mem_rdata = d_rdata_q;
    assign bus.i_mem_ready = i_ready_q;
    assign bus.d_mem_ready = d_ready_q;
endmodule
